// File: rtl/reg_16_if.sv
// reg_16_if: write strobe, write data, read enables and the two shared
// tri-state read buses of one register-file storage element.
interface reg_16_if #(
  parameter int WIDTH = 16
);
  logic             ld;
  logic [WIDTH-1:0] Din;
  logic             oeA;
  logic             oeB;
  tri   [WIDTH-1:0] DA;
  tri   [WIDTH-1:0] DB;

  // Decoder / bus owner side
  modport master (
    output ld,
    output Din,
    output oeA,
    output oeB,
    input  DA,
    input  DB
  );

  // Storage element side
  modport slave (
    input  ld,
    input  Din,
    input  oeA,
    input  oeB,
    output DA,
    output DB
  );
endinterface

// File: rtl/reg_16.sv
// reg_16: one WIDTH-bit storage word of the CPU register file.
// Loads from the shared write bus on a rising clk edge when ld is high, and
// drives its value onto either or both shared read buses when enabled.
// Unselected ports float per bit so many instances can share DA/DB.
module reg_16 #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = 16'h0000
) (
  input logic   clk,
  input logic   reset,
  reg_16_if.slave bus
);

  logic [WIDTH-1:0] q;

  // Storage word: async clear to RESET_VALUE, otherwise capture Din on ld
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= RESET_VALUE;
    end else if (bus.ld) begin
      q <= bus.Din;
    end else begin
      q <= q;
    end
  end

  // Read ports are zero-latency: no bypass from Din, only the stored word
  assign bus.DA = bus.oeA ? q : {WIDTH{1'bz}};
  assign bus.DB = bus.oeB ? q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_reg_16.sv
// tb_reg_16: directed plus randomized checks of reg_16 against a simple
// behavioural model (one word of storage updated by the bench's own strobes).
// Floating ports are detected by a second, bench-owned driver on each bus:
// a released port must let that driver's value through unchanged.
module tb_reg_16;

  logic clk;
  logic reset;

  reg_16_if #(.WIDTH(16)) bus ();

  reg_16 #(
    .WIDTH       (16),
    .RESET_VALUE (16'h0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Bench-side competing drivers, enabled only when the DUT port must float
  logic        tb_en_a;
  logic        tb_en_b;
  logic [15:0] tb_val_a;
  logic [15:0] tb_val_b;
  assign bus.DA = tb_en_a ? tb_val_a : 16'hzzzz;
  assign bus.DB = tb_en_b ? tb_val_b : 16'hzzzz;

  int          checks;
  int          failures;
  logic [15:0] exp_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and apply the storage rule to the model
  task automatic tick();
    @(posedge clk);
    if (reset && bus.ld) exp_q = bus.Din;
    #1;
  endtask

  // Assert reset: the model word is cleared at once
  task automatic assert_reset();
    reset = 1'b0;
    exp_q = 16'h0000;
  endtask

  // Compare both read ports against the model (enabled) or the bench driver (floating)
  task automatic check_ports(input string tag);
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    tb_val_a = ~exp_q;
    tb_val_b = ~exp_q ^ 16'h8001;
    tb_en_a  = !bus.oeA;
    tb_en_b  = !bus.oeB;
    #1;
    exp_a = bus.oeA ? exp_q : tb_val_a;
    exp_b = bus.oeB ? exp_q : tb_val_b;
    checks++;
    assert (bus.DA === exp_a) else begin
      failures++;
      $error("FAIL %s.DA observed=%h expected=%h", tag, bus.DA, exp_a);
    end
    checks++;
    assert (bus.DB === exp_b) else begin
      failures++;
      $error("FAIL %s.DB observed=%h expected=%h", tag, bus.DB, exp_b);
    end
    tb_en_a = 1'b0;
    tb_en_b = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    tb_en_a  = 1'b0;
    tb_en_b  = 1'b0;
    tb_val_a = 16'h0000;
    tb_val_b = 16'h0000;
    bus.ld   = 1'b0;
    bus.Din  = 16'h0000;
    bus.oeA  = 1'b0;
    bus.oeB  = 1'b0;
    assert_reset();

    // Reset state
    tick();
    tick();
    bus.oeA = 1'b1;
    bus.oeB = 1'b1;
    check_ports("reset_state");
    reset = 1'b1;
    tick();
    check_ports("reset_release");

    // Load BEEF, then an async reset without a clock edge clears it
    bus.ld  = 1'b1;
    bus.Din = 16'hBEEF;
    tick();
    bus.ld  = 1'b0;
    check_ports("load_beef");
    assert_reset();
    check_ports("async_clear");
    reset = 1'b1;
    tick();
    check_ports("release_no_load");

    // Load then read on A only
    bus.ld  = 1'b1;
    bus.Din = 16'h1234;
    bus.oeA = 1'b0;
    bus.oeB = 1'b0;
    tick();
    bus.ld  = 1'b0;
    bus.oeA = 1'b1;
    bus.oeB = 1'b0;
    check_ports("load_1234");

    // Hold while Din changes
    bus.Din = 16'hFFFF;
    bus.oeB = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_ports("hold");
    end

    // Tri-state, then enable B without any clock edge
    bus.oeA = 1'b0;
    bus.oeB = 1'b0;
    check_ports("both_float");
    bus.oeB = 1'b1;
    check_ports("oeb_only");

    // Patterns k and 7-k, then alternating bits
    bus.oeA = 1'b1;
    bus.oeB = 1'b1;
    bus.ld  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.Din = 16'(k);
      tick();
      check_ports("pattern_k");
      bus.Din = 16'(7 - k);
      tick();
      check_ports("pattern_7mk");
    end
    bus.Din = 16'hAAAA;
    tick();
    check_ports("pattern_aaaa");
    bus.Din = 16'h5555;
    tick();
    check_ports("pattern_5555");

    // Mid-cycle reset pulse with ld held high: no load while reset is low
    bus.Din = 16'hCAFE;
    assert_reset();
    check_ports("mid_reset_clear");
    tick();
    check_ports("mid_reset_edge_blocked");
    reset = 1'b1;
    check_ports("mid_reset_released");
    tick();
    check_ports("mid_reset_load_cafe");

    // Randomized strobes, data, enables and occasional reset pulses
    for (int i = 0; i < 80; i++) begin
      bus.ld  = 1'($urandom_range(1, 0));
      bus.Din = 16'($urandom);
      bus.oeA = 1'($urandom_range(1, 0));
      bus.oeB = 1'($urandom_range(1, 0));
      if ($urandom_range(15, 0) == 0) begin
        assert_reset();
        check_ports("rand_reset");
      end
      tick();
      check_ports("rand");
      reset = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
